// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the multi-cycle RV32I core.
//               Holds the PC sequencer state encoding, the default reset PC,
//               the instruction size, and an alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } pcseq_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  // A target is usable only when it sits on a 4-byte instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bundle of the PC sequencer's bus-facing signals.
//               imem_*     : fetch request/response with instruction memory
//               instr*     : instruction hand-off to decode
//               redirect_* : control-flow redirect from execute
//               master = sequencer side, slave = memory/decode/execute side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_ready, redirect_valid, redirect_target
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. Owns the PC, issues one fetch at a
//               time, holds the returned word for decode, applies redirects
//               from execute, discards fetches made stale by a redirect,
//               traps misaligned targets and counts accepted instructions.
// Ports       : clk, rst_n     - clock, async active-low reset
//               bus (master)   - imem / decode / redirect signals
//               fault          - sticky misaligned-target fault
//               fetch_count    - instructions accepted by decode (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pc_sequencer_if.master     bus,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  pcseq_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fault_q, fault_d;
  logic [31:0]     count_q, count_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic [XLEN-1:0] resolved_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fault_q       <= 1'b0;
      count_q       <= '0;
      kill_q        <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
      count_q       <= count_d;
      kill_q        <= kill_d;
      pend_target_q <= pend_target_d;
    end
  end

  // When a stale fetch completes, a redirect arriving in that same cycle is
  // newer than anything parked in pend_target.
  assign resolved_target = bus.redirect_valid ? bus.redirect_target : pend_target_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_d       = fault_q;
    count_d       = count_q;
    kill_d        = kill_q;
    pend_target_d = pend_target_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_target;
          if (is_misaligned(bus.redirect_target[1:0])) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
      end

      FETCH: begin
        if (bus.imem_ready) begin
          if (kill_q || bus.redirect_valid) begin
            // Stale response: drop rdata and restart at the newest target.
            pc_d   = resolved_target;
            kill_d = 1'b0;
            if (is_misaligned(resolved_target[1:0])) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + XLEN'(INSTR_BYTES);
            state_d    = HOLD;
          end
        end else if (bus.redirect_valid) begin
          // The request in flight must stay stable, so park the target and
          // apply it once memory answers.
          kill_d        = 1'b1;
          pend_target_d = bus.redirect_target;
        end
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_target;
          if (is_misaligned(bus.redirect_target[1:0])) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end else if (bus.instr_ready) begin
          count_d = count_q + 32'd1;
          state_d = FETCH;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign fault           = fault_q;
  assign fetch_count     = count_q;

endmodule
`default_nettype wire
